// File: rtl/ibuf_read_scheduler_pkg.sv
// ibuf_read_scheduler_pkg
// Shared definitions for the input-buffer read scheduler: FSM state encoding,
// bank rotation constants, buffer pointer encoding and the bank-advance helper.
package ibuf_read_scheduler_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitBuf,
      StRead,
      StRowEnd,
      StDone
   } state_t;

   localparam logic [1:0] BANK_0     = 2'd0;
   localparam logic [1:0] BANK_1     = 2'd1;
   localparam logic [1:0] BANK_2     = 2'd2;
   localparam logic [1:0] KERNEL_3X3 = 2'd3;

   // Ping-pong buffer pointer encoding
   localparam logic BUF_A = 1'b0;
   localparam logic BUF_B = 1'b1;

   // Bank rotation only applies to 3x3 kernels; any other kernel pins bank 0.
   function automatic logic [1:0] next_bank(input logic [1:0] bank, input logic [1:0] kernel);
      logic [1:0] nb;
      nb = BANK_0;
      if (kernel == KERNEL_3X3) begin
         case (bank)
            BANK_0:  nb = BANK_1;
            BANK_1:  nb = BANK_2;
            default: nb = BANK_0;
         endcase
      end
      return nb;
   endfunction

endpackage

// File: rtl/ibuf_read_scheduler_addr_gen.sv
// ibuf_addr_gen
// Address / bit-serial counter pair. The bit-serial phase counts 0..bs_wait for
// every address; the address counts 0..length-1. Both wrap to 0 after the final
// phase of the final address so they never leave their configured range.
// Ports:
//   clk, rst    clock, async active-high reset
//   clear       force both counters to 0 (priority over enable)
//   enable      advance the counters this cycle
//   length      words per row pass (must be non-zero while enabled)
//   bs_wait     last bit-serial phase per address
//   addr        current read address
//   bit_serial  current bit-serial phase
//   last        final phase of final address
module ibuf_addr_gen #(
   parameter int unsigned ADDR_SIZE = 13,
   parameter int unsigned BS_SIZE   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [ADDR_SIZE-1:0] length,
   input  logic [BS_SIZE-1:0]   bs_wait,
   output logic [ADDR_SIZE-1:0] addr,
   output logic [BS_SIZE-1:0]   bit_serial,
   output logic                 last
);

   logic [ADDR_SIZE-1:0] addr_q;
   logic [BS_SIZE-1:0]   bs_q;
   logic                 bs_wrap;

   assign bs_wrap = (bs_q == bs_wait);
   assign last    = bs_wrap && (addr_q == (length - ADDR_SIZE'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         bs_q   <= '0;
      end else if (clear) begin
         addr_q <= '0;
         bs_q   <= '0;
      end else if (enable) begin
         if (last) begin
            addr_q <= '0;
            bs_q   <= '0;
         end else if (bs_wrap) begin
            addr_q <= addr_q + ADDR_SIZE'(1);
            bs_q   <= '0;
         end else begin
            bs_q <= bs_q + BS_SIZE'(1);
         end
      end
   end

   assign addr       = addr_q;
   assign bit_serial = bs_q;

endmodule

// File: rtl/ibuf_read_scheduler.sv
// ibuf_read_scheduler
// Sequences row-pass reads from the ping-pong input buffers into the PE array.
// Waits for the loader to fill the current buffer, reads it for one row pass,
// releases it, flips to the other buffer and rotates the bank state.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    one-cycle pulse, begin a layer pass (ignored when busy)
//   cfg_kernel_size          kernel size; 3 enables bank rotation
//   cfg_length               words per row pass
//   cfg_rows                 row passes per layer
//   cfg_bs_wait              last bit-serial phase per address
//   buf_a_ready/buf_b_ready  loader has filled buffer A / B
//   on_to_pe_addr            buffer read address
//   bank_state               bank rotation 0,1,2
//   ibuf_rd_a/ibuf_rd_b      reading buffer A / B
//   bit_serial               bit-serial phase
//   buf_a_release/_b_release one-cycle pulse, buffer consumed
//   busy                     high from start acceptance to done
//   done                     one-cycle pulse at layer end
module ibuf_read_scheduler
   import ibuf_read_scheduler_pkg::*;
#(
   parameter int unsigned ADDR_SIZE    = 13,
   parameter int unsigned ROW_CNT_SIZE = 10,
   parameter int unsigned BS_SIZE      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              cfg_kernel_size,
   input  logic [ADDR_SIZE-1:0]    cfg_length,
   input  logic [ROW_CNT_SIZE-1:0] cfg_rows,
   input  logic [BS_SIZE-1:0]      cfg_bs_wait,
   input  logic                    buf_a_ready,
   input  logic                    buf_b_ready,
   output logic [ADDR_SIZE-1:0]    on_to_pe_addr,
   output logic [1:0]              bank_state,
   output logic                    ibuf_rd_a,
   output logic                    ibuf_rd_b,
   output logic [BS_SIZE-1:0]      bit_serial,
   output logic                    buf_a_release,
   output logic                    buf_b_release,
   output logic                    busy,
   output logic                    done
);

   state_t                  state_q;
   logic                    ptr_q;
   logic [ROW_CNT_SIZE-1:0] rows_done_q;
   logic [ADDR_SIZE-1:0]    len_q;
   logic [ROW_CNT_SIZE-1:0] rows_q;
   logic [BS_SIZE-1:0]      wait_q;
   logic [1:0]              kernel_q;
   logic [1:0]              bank_q;
   logic                    rd_a_q, rd_b_q;
   logic                    rel_a_q, rel_b_q;
   logic                    busy_q, done_q;

   logic cur_ready;
   logic ag_last;

   // Only the buffer under the pointer is ever considered.
   assign cur_ready = (ptr_q == BUF_B) ? buf_b_ready : buf_a_ready;

   ibuf_addr_gen #(
      .ADDR_SIZE (ADDR_SIZE),
      .BS_SIZE   (BS_SIZE)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_q != StRead),
      .enable     (state_q == StRead),
      .length     (len_q),
      .bs_wait    (wait_q),
      .addr       (on_to_pe_addr),
      .bit_serial (bit_serial),
      .last       (ag_last)
   );

   // Outputs are registered and updated on the transition into each state so
   // they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= BUF_A;
         rows_done_q <= '0;
         len_q       <= '0;
         rows_q      <= '0;
         wait_q      <= '0;
         kernel_q    <= '0;
         bank_q      <= BANK_0;
         rd_a_q      <= 1'b0;
         rd_b_q      <= 1'b0;
         rel_a_q     <= 1'b0;
         rel_b_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         rel_a_q <= 1'b0;
         rel_b_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  len_q       <= cfg_length;
                  rows_q      <= cfg_rows;
                  wait_q      <= cfg_bs_wait;
                  kernel_q    <= cfg_kernel_size;
                  busy_q      <= 1'b1;
                  ptr_q       <= BUF_A;
                  rows_done_q <= '0;
                  bank_q      <= BANK_0;
                  state_q     <= StWaitBuf;
               end
            end
            StWaitBuf: begin
               // Empty layers are detected here, against the latched config.
               if ((len_q == '0) || (rows_q == '0)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else if (cur_ready) begin
                  rd_a_q  <= (ptr_q == BUF_A);
                  rd_b_q  <= (ptr_q == BUF_B);
                  state_q <= StRead;
               end
            end
            StRead: begin
               if (ag_last) begin
                  rd_a_q      <= 1'b0;
                  rd_b_q      <= 1'b0;
                  rel_a_q     <= (ptr_q == BUF_A);
                  rel_b_q     <= (ptr_q == BUF_B);
                  ptr_q       <= ~ptr_q;
                  rows_done_q <= rows_done_q + ROW_CNT_SIZE'(1);
                  bank_q      <= next_bank(bank_q, kernel_q);
                  state_q     <= StRowEnd;
               end
            end
            StRowEnd: begin
               // rows_done_q already counts the row just finished.
               if (rows_done_q == rows_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  state_q <= StWaitBuf;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bank_state    = bank_q;
   assign ibuf_rd_a     = rd_a_q;
   assign ibuf_rd_b     = rd_b_q;
   assign buf_a_release = rel_a_q;
   assign buf_b_release = rel_b_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_ibuf_read_scheduler.sv
module tb_ibuf_read_scheduler;

   localparam int unsigned ADDR_SIZE    = 13;
   localparam int unsigned ROW_CNT_SIZE = 10;
   localparam int unsigned BS_SIZE      = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [1:0]              cfg_kernel_size;
   logic [ADDR_SIZE-1:0]    cfg_length;
   logic [ROW_CNT_SIZE-1:0] cfg_rows;
   logic [BS_SIZE-1:0]      cfg_bs_wait;
   logic                    buf_a_ready;
   logic                    buf_b_ready;
   logic [ADDR_SIZE-1:0]    on_to_pe_addr;
   logic [1:0]              bank_state;
   logic                    ibuf_rd_a;
   logic                    ibuf_rd_b;
   logic [BS_SIZE-1:0]      bit_serial;
   logic                    buf_a_release;
   logic                    buf_b_release;
   logic                    busy;
   logic                    done;

   ibuf_read_scheduler #(
      .ADDR_SIZE    (ADDR_SIZE),
      .ROW_CNT_SIZE (ROW_CNT_SIZE),
      .BS_SIZE      (BS_SIZE)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cfg_kernel_size (cfg_kernel_size),
      .cfg_length      (cfg_length),
      .cfg_rows        (cfg_rows),
      .cfg_bs_wait     (cfg_bs_wait),
      .buf_a_ready     (buf_a_ready),
      .buf_b_ready     (buf_b_ready),
      .on_to_pe_addr   (on_to_pe_addr),
      .bank_state      (bank_state),
      .ibuf_rd_a       (ibuf_rd_a),
      .ibuf_rd_b       (ibuf_rd_b),
      .bit_serial      (bit_serial),
      .buf_a_release   (buf_a_release),
      .buf_b_release   (buf_b_release),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic                 rd_a;
      logic                 rd_b;
      logic                 busy;
      logic [ADDR_SIZE-1:0] addr;
      logic [BS_SIZE-1:0]   bs;
      logic [1:0]           bank;
   } beat_t;

   beat_t      exp_q[$];
   logic [1:0] rel_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_cycles = 0;
   int rel_cycle = 0;
   int done_cycle = 0;
   int refill_delay = -1;
   int a_cnt = -1;
   int b_cnt = -1;
   bit sb_on = 1'b1;

   beat_t      mon_got;
   beat_t      mon_exp;
   logic [1:0] mon_rel;

   always @(posedge clk) cyc++;

   // Scoreboard monitor: every read beat and release pulse pops an expectation.
   always @(negedge clk) begin
      if (sb_on && !rst) begin
         if (ibuf_rd_a || ibuf_rd_b) begin
            rd_cycles++;
            mon_got = '{rd_a: ibuf_rd_a, rd_b: ibuf_rd_b, busy: busy, addr: on_to_pe_addr,
                        bs: bit_serial, bank: bank_state};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL read_beat unexpected got=%h required=none", mon_got);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_got !== mon_exp) begin
                  errors++;
                  $display("FAIL read_beat got rda=%0b rdb=%0b busy=%0b addr=%0d bs=%0d bank=%0d required rda=%0b rdb=%0b busy=%0b addr=%0d bs=%0d bank=%0d",
                           mon_got.rd_a, mon_got.rd_b, mon_got.busy, mon_got.addr, mon_got.bs,
                           mon_got.bank, mon_exp.rd_a, mon_exp.rd_b, mon_exp.busy, mon_exp.addr,
                           mon_exp.bs, mon_exp.bank);
               end
            end
         end
         if (buf_a_release || buf_b_release) begin
            rel_cycle = cyc;
            checks++;
            if (rel_q.size() == 0) begin
               errors++;
               $display("FAIL release unexpected got=%b%b required=none",
                        buf_a_release, buf_b_release);
            end else begin
               mon_rel = rel_q.pop_front();
               if ({buf_a_release, buf_b_release} !== mon_rel) begin
                  errors++;
                  $display("FAIL release got=%b%b required=%b",
                           buf_a_release, buf_b_release, mon_rel);
               end
            end
         end
      end
   end

   task automatic push_layer(input int len, input int rows, input int bsw, input int kern);
      for (int r = 0; r < rows; r++) begin
         for (int a = 0; a < len; a++) begin
            for (int b = 0; b <= bsw; b++) begin
               beat_t e;
               e.rd_a = ((r % 2) == 0);
               e.rd_b = ((r % 2) == 1);
               e.busy = 1'b1;
               e.addr = ADDR_SIZE'(a);
               e.bs   = BS_SIZE'(b);
               e.bank = (kern == 3) ? 2'(r % 3) : 2'd0;
               exp_q.push_back(e);
            end
         end
         if ((r % 2) == 0) rel_q.push_back(2'b10);
         else rel_q.push_back(2'b01);
      end
   endtask

   // Drives start for one cycle, then scrambles cfg to prove it was latched.
   task automatic start_layer(input int len, input int rows, input int bsw, input int kern);
      @(negedge clk);
      cfg_length      = ADDR_SIZE'(len);
      cfg_rows        = ROW_CNT_SIZE'(rows);
      cfg_bs_wait     = BS_SIZE'(bsw);
      cfg_kernel_size = 2'(kern);
      start           = 1'b1;
      @(negedge clk);
      start           = 1'b0;
      cfg_length      = 13'd5;
      cfg_rows        = 10'd7;
      cfg_bs_wait     = 4'd2;
      cfg_kernel_size = 2'd0;
   endtask

   // Loader model: drop ready on release, refill after refill_delay cycles.
   task automatic loader_cycle();
      @(negedge clk);
      if (buf_a_release) begin
         buf_a_ready = 1'b0;
         a_cnt = refill_delay;
      end else if (a_cnt > 0) a_cnt--;
      else if (a_cnt == 0) begin
         buf_a_ready = 1'b1;
         a_cnt = -1;
      end
      if (buf_b_release) begin
         buf_b_ready = 1'b0;
         b_cnt = refill_delay;
      end else if (b_cnt > 0) b_cnt--;
      else if (b_cnt == 0) begin
         buf_b_ready = 1'b1;
         b_cnt = -1;
      end
   endtask

   task automatic wait_done(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         loader_cycle();
         if (done) begin
            got = 1'b1;
            done_cycle = cyc;
            break;
         end
      end
   endtask

   task automatic setup(input logic ra, input logic rb, input int delay);
      buf_a_ready  = ra;
      buf_b_ready  = rb;
      refill_delay = delay;
      a_cnt        = -1;
      b_cnt        = -1;
      rd_cycles    = 0;
      exp_q.delete();
      rel_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      cfg_kernel_size = '0;
      cfg_length = '0;
      cfg_rows = '0;
      cfg_bs_wait = '0;
      buf_a_ready = 1'b0;
      buf_b_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({on_to_pe_addr, bank_state, ibuf_rd_a, ibuf_rd_b, bit_serial, buf_a_release,
           buf_b_release, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got addr=%0d bank=%0d rd=%b%b bs=%0d rel=%b%b busy=%b done=%b required all 0",
                  on_to_pe_addr, bank_state, ibuf_rd_a, ibuf_rd_b, bit_serial, buf_a_release,
                  buf_b_release, busy, done);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bit got;
      setup(1'b1, 1'b0, -1);
      push_layer(4, 1, 0, 3);
      start_layer(4, 1, 0, 3);
      wait_done(100, got);
      checks++;
      if (!got) begin errors++; $display("FAIL basic_done got=timeout required=done"); end
      checks++;
      if (rd_cycles != 4) begin
         errors++; $display("FAIL basic_read_cycles got=%0d required=4", rd_cycles);
      end
      checks++;
      if (done_cycle - rel_cycle != 1) begin
         errors++; $display("FAIL basic_done_latency got=%0d required=1", done_cycle - rel_cycle);
      end
      checks++;
      if (bank_state !== 2'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_end_state got bank=%0d busy=%b required bank=1 busy=0",
                  bank_state, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b required=0", done); end
      checks++;
      if (exp_q.size() != 0 || rel_q.size() != 0) begin
         errors++;
         $display("FAIL basic_leftover got=%0d/%0d required=0/0", exp_q.size(), rel_q.size());
      end
   endtask

   task automatic test_bit_serial();
      bit got;
      setup(1'b1, 1'b0, -1);
      push_layer(2, 1, 3, 0);
      start_layer(2, 1, 3, 0);
      wait_done(100, got);
      checks++;
      if (!got || rd_cycles != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bit_serial got done=%b reads=%0d left=%0d required done=1 reads=8 left=0",
                  got, rd_cycles, exp_q.size());
      end
   endtask

   task automatic test_ping_pong();
      bit got;
      setup(1'b1, 1'b1, 2);
      push_layer(3, 4, 0, 3);
      start_layer(3, 4, 0, 3);
      wait_done(300, got);
      checks++;
      if (!got || rd_cycles != 12 || exp_q.size() != 0 || rel_q.size() != 0) begin
         errors++;
         $display("FAIL ping_pong got done=%b reads=%0d left=%0d/%0d required done=1 reads=12 left=0/0",
                  got, rd_cycles, exp_q.size(), rel_q.size());
      end
      checks++;
      if (bank_state !== 2'd1) begin
         errors++; $display("FAIL ping_pong_bank got=%0d required=1", bank_state);
      end
   endtask

   task automatic test_stall();
      bit got;
      bit seen;
      setup(1'b1, 1'b0, -1);
      push_layer(3, 2, 1, 3);
      start_layer(3, 2, 1, 3);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         loader_cycle();
         if (buf_a_release) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL stall_release_a got=timeout required=pulse"); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (ibuf_rd_a || ibuf_rd_b || on_to_pe_addr != 0 || bit_serial != 0 || !busy) begin
            errors++;
            $display("FAIL stall_wait got rd=%b%b addr=%0d bs=%0d busy=%b required rd=00 addr=0 bs=0 busy=1",
                     ibuf_rd_a, ibuf_rd_b, on_to_pe_addr, bit_serial, busy);
         end
      end
      buf_b_ready = 1'b1;
      wait_done(100, got);
      checks++;
      if (!got || exp_q.size() != 0 || rel_q.size() != 0) begin
         errors++;
         $display("FAIL stall_resume got done=%b left=%0d/%0d required done=1 left=0/0",
                  got, exp_q.size(), rel_q.size());
      end
   endtask

   task automatic test_kernel1();
      bit got;
      setup(1'b1, 1'b1, 1);
      push_layer(2, 3, 0, 1);
      start_layer(2, 3, 0, 1);
      wait_done(200, got);
      checks++;
      if (!got || bank_state !== 2'd0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL kernel1 got done=%b bank=%0d left=%0d required done=1 bank=0 left=0",
                  got, bank_state, exp_q.size());
      end
   endtask

   task automatic test_empty_layer(input int len, input int rows);
      setup(1'b1, 1'b1, -1);
      start_layer(len, rows, 0, 3);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL empty_first got done=%b busy=%b required done=0 busy=1", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL empty_done got done=%b busy=%b required done=1 busy=0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || rd_cycles != 0) begin
         errors++;
         $display("FAIL empty_after got done=%b reads=%0d required done=0 reads=0", done, rd_cycles);
      end
   endtask

   task automatic test_reset_mid_read();
      bit found;
      setup(1'b1, 1'b1, 1);
      sb_on = 1'b0;
      start_layer(4, 3, 1, 3);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         loader_cycle();
         if (ibuf_rd_b && bit_serial == 1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found || bank_state !== 2'd1) begin
         errors++;
         $display("FAIL midread_reach got found=%b bank=%0d required found=1 bank=1",
                  found, bank_state);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({on_to_pe_addr, bank_state, ibuf_rd_a, ibuf_rd_b, bit_serial, buf_a_release,
           buf_b_release, busy, done} !== '0) begin
         errors++;
         $display("FAIL midread_reset got addr=%0d bank=%0d rd=%b%b bs=%0d busy=%b required all 0",
                  on_to_pe_addr, bank_state, ibuf_rd_a, ibuf_rd_b, bit_serial, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (ibuf_rd_a || ibuf_rd_b || buf_a_release || buf_b_release || done || busy) begin
            errors++;
            $display("FAIL midread_quiet got rd=%b%b rel=%b%b done=%b busy=%b required all 0",
                     ibuf_rd_a, ibuf_rd_b, buf_a_release, buf_b_release, done, busy);
         end
      end
      sb_on = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bit_serial();
      test_ping_pong();
      test_stall();
      test_kernel1();
      test_empty_layer(0, 2);
      test_empty_layer(4, 0);
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
